// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Circular instruction fetch queue between the fetch unit and decode.
//   Words pushed on the input side are held in DEPTH entries and presented
//   to decode in FIFO order, split into opcode (low OP_W bits) and adir
//   (remaining high bits). A flush discards every queued word.
//
// Ports
//   clk       : clock, rising-edge
//   rst       : synchronous active-high reset
//   in_valid  : mdat carries a fetched word
//   mdat      : fetched instruction word
//   in_ready  : queue can accept a word this cycle (not full)
//   flush     : drop all queued words; beats push and pop
//   out_ready : decode consumes the head word this cycle
//   out_valid : head word present (not empty)
//   opcode    : head word bits [OP_W-1:0], zero when empty
//   adir      : head word bits [DATA_W-1:OP_W], zero when empty
//   count     : number of queued words, 0..DEPTH
module instr_fetch_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          mdat,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OP_W-1:0]            opcode,
  output logic [DATA_W-OP_W-1:0]     adir,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Handshake flags depend only on registered count, so a pop cannot
  // open room for a same-cycle push when full.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap to 0.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; it is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= mdat;
  end

  assign head   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign opcode = head[OP_W-1:0];
  assign adir   = head[DATA_W-1:OP_W];
  assign count  = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] mdat;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  opcode;
  logic [12:0] adir;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] wl [8];

  instr_fetch_queue #(.DATA_W(16), .OP_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mdat      (mdat),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .opcode    (opcode),
    .adir      (adir),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1;
    mdat     = w;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    wl[0] = 16'h1111; wl[1] = 16'h2222; wl[2] = 16'h3333; wl[3] = 16'h4444;
    wl[4] = 16'h5555; wl[5] = 16'h6666; wl[6] = 16'h7777; wl[7] = 16'h8888;
    rst = 1'b1; in_valid = 1'b0; mdat = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_adir", 32'(adir), 0);

    // Single push, no bypass in the accepting cycle.
    in_valid = 1'b1; mdat = 16'hABCD;
    #1 check("no_bypass", 32'(out_valid), 0);
    step(); in_valid = 1'b0;
    check("p1_valid", 32'(out_valid), 1);
    check("p1_opcode", 32'(opcode), 32'h5);
    check("p1_adir", 32'(adir), 32'h1579);
    check("p1_count", 32'(count), 1);

    // Hold head stable with out_ready low.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_opcode", 32'(opcode), 32'h5);
      check("hold_adir", 32'(adir), 32'h1579);
      check("hold_count", 32'(count), 1);
    end
    out_ready = 1'b1; step();
    check("pop1_count", 32'(count), 0);
    check("pop1_valid", 32'(out_valid), 0);
    step();
    check("empty_pop_count", 32'(count), 0);
    check("empty_pop_opcode", 32'(opcode), 0);
    check("empty_pop_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;

    // Fill to full, then reject further words.
    push_word(16'h0001); push_word(16'h0002);
    push_word(16'h0003); push_word(16'h0004);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1; mdat = 16'h0005; step();
    check("full_reject_count", 32'(count), 4);
    check("full_head", 32'(opcode), 1);
    // Pop while full with in_valid high: pop only.
    out_ready = 1'b1; step(); in_valid = 1'b0;
    check("full_pop_count", 32'(count), 3);
    for (int i = 2; i <= 4; i++) begin
      check("drain_opcode", 32'(opcode), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count), 0);
    check("drain_valid", 32'(out_valid), 0);

    // Steady push+pop at count 2 across pointer wrap.
    push_word(wl[0]); push_word(wl[1]);
    check("pp_start_count", 32'(count), 2);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mdat = wl[k+2];
      check("pp_head", 32'({adir, opcode}), 32'(wl[k]));
      step();
      check("pp_count", 32'(count), 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_tail_head", 32'({adir, opcode}), 32'(wl[6]));

    // Flush beats push and pop at count 3.
    push_word(16'h9999);
    check("fl_pre_count", 32'(count), 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mdat = 16'hAAAA;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_count", 32'(count), 0);
    check("fl_valid", 32'(out_valid), 0);
    check("fl_opcode", 32'(opcode), 0);
    check("fl_adir", 32'(adir), 0);
    step();
    check("fl_lost_count", 32'(count), 0);

    // Reset mid-stream beats push.
    push_word(16'h0101); push_word(16'h0202); push_word(16'h0303);
    check("rs_pre_count", 32'(count), 3);
    rst = 1'b1; in_valid = 1'b1; mdat = 16'h0404;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rs_count", 32'(count), 0);
    check("rs_in_ready", 32'(in_ready), 1);
    check("rs_valid", 32'(out_valid), 0);
    push_word(16'hBEEF);
    check("rs_after_head", 32'({adir, opcode}), 32'h0000BEEF);
    check("rs_after_count", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
